// File: rtl/lasernet_pkg.sv
// Shared LaserNet definitions: header length, flag bit positions, and the
// packet_builder state encoding. Also used by the controller and receive parser.
// The CSUM state exists only when PKT_CHECKSUM_EN is defined.
package lasernet_pkg;

    localparam int unsigned HDR_BYTES = 10;
    localparam int unsigned FLAGS_W   = 9;

    localparam int unsigned FLAG_ACK = 4;
    localparam int unsigned FLAG_SYN = 1;
    localparam int unsigned FLAG_FIN = 0;

    // Encodings are fixed so the state values match across build variants.
    typedef enum logic [2:0] {
        PB_IDLE   = 3'd0,
        PB_HDR    = 3'd1,
        PB_PAY_RD = 3'd2,
        PB_PAY    = 3'd3,
`ifdef PKT_CHECKSUM_EN
        PB_CSUM   = 3'd4,
`endif
        PB_DONE   = 3'd5
    } pb_state_t;

    // Only plain data packets carry payload; SYN and FIN packets are header-only.
    function automatic logic has_payload(input logic [FLAGS_W-1:0] flags);
        return !flags[FLAG_SYN] && !flags[FLAG_FIN];
    endfunction

endpackage

// File: rtl/pkt_byte_mux.sv
// Header byte selector: picks one of the 10 header bytes (SEQ, ACK, flags,
// all MSB first) from the fields latched by packet_builder.
module pkt_byte_mux
    import lasernet_pkg::*;
(
    input  logic [31:0]        seq,
    input  logic [31:0]        ack,
    input  logic [FLAGS_W-1:0] flags,
    input  logic [3:0]         sel,
    output logic [7:0]         hdr_byte
);

    // Byte-index to header-field selection.
    always_comb begin
        hdr_byte = '0;
        case (sel)
            4'd0:    hdr_byte = seq[31:24];
            4'd1:    hdr_byte = seq[23:16];
            4'd2:    hdr_byte = seq[15:8];
            4'd3:    hdr_byte = seq[7:0];
            4'd4:    hdr_byte = ack[31:24];
            4'd5:    hdr_byte = ack[23:16];
            4'd6:    hdr_byte = ack[15:8];
            4'd7:    hdr_byte = ack[7:0];
            4'd8:    hdr_byte = {7'b0, flags[8]};
            4'd9:    hdr_byte = flags[7:0];
            default: hdr_byte = '0;
        endcase
    end

endmodule

// File: rtl/packet_builder.sv
// Packet framer: on start, latches SEQ/ACK/flags and streams header, optional
// payload (read from synchronous data RAM) and optional checksum to the
// serializer over valid/ready. Pulses packetsent once the packet is done.
// Optional feature macro: PKT_CHECKSUM_EN (adds a trailing XOR checksum byte).
module packet_builder
    import lasernet_pkg::*;
#(
    parameter int unsigned PAYLOAD_BYTES = 16,
    parameter int unsigned ADDR_W        = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [31:0]        seq_in,
    input  logic [31:0]        ack_in,
    input  logic [FLAGS_W-1:0] flags_in,
    input  logic [31:0]        isn,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [7:0]         mem_rdata,
    output logic [7:0]         out_byte,
    output logic               out_valid,
    output logic               out_last,
    input  logic               out_ready,
    output logic               packetsent,
    output logic               busy
);

    localparam logic [3:0] LAST_HDR = 4'(HDR_BYTES - 1);
    localparam logic [7:0] LAST_K   = 8'(PAYLOAD_BYTES - 1);

`ifdef PKT_CHECKSUM_EN
    localparam logic      CSUM_ON   = 1'b1;
    localparam pb_state_t AFTER_PAY = PB_CSUM;
`else
    localparam logic      CSUM_ON   = 1'b0;
    localparam pb_state_t AFTER_PAY = PB_DONE;
`endif

    pb_state_t           state;
    pb_state_t           state_nxt;

    logic [31:0]         seq_q;
    logic [31:0]         ack_q;
    logic [FLAGS_W-1:0]  flags_q;
    logic [ADDR_W-1:0]   base_q;
    logic [3:0]          hdr_cnt;
    logic [7:0]          k_q;
    logic [7:0]          pay_q;
    logic                pay_held;
    logic [7:0]          hdr_byte;
    logic [31:0]         idx_w;
    logic                pay_en;
    logic                hs;
`ifdef PKT_CHECKSUM_EN
    logic [7:0]          csum_q;
`endif

    assign idx_w  = seq_in - isn;
    assign pay_en = has_payload(flags_q);
    assign hs     = out_valid & out_ready;

    pkt_byte_mux u_byte_mux (
        .seq      (seq_q),
        .ack      (ack_q),
        .flags    (flags_q),
        .sel      (hdr_cnt),
        .hdr_byte (hdr_byte)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= PB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and stream outputs; sections advance only on a handshake.
    always_comb begin
        state_nxt  = state;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_byte   = '0;
        packetsent = 1'b0;
        busy       = 1'b1;
        case (state)
            PB_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = PB_HDR;
                end
            end
            PB_HDR: begin
                out_valid = 1'b1;
                out_byte  = hdr_byte;
                out_last  = (hdr_cnt == LAST_HDR) && !pay_en && !CSUM_ON;
                if (out_ready && (hdr_cnt == LAST_HDR)) begin
                    state_nxt = pay_en ? PB_PAY_RD : AFTER_PAY;
                end
            end
            PB_PAY_RD: begin
                state_nxt = PB_PAY;
            end
            PB_PAY: begin
                // The RAM word is forwarded on the first PAY cycle and held in
                // pay_q afterwards, so a stall cannot disturb the byte.
                out_valid = 1'b1;
                out_byte  = pay_held ? pay_q : mem_rdata;
                out_last  = (k_q == LAST_K) && !CSUM_ON;
                if (out_ready) begin
                    state_nxt = (k_q == LAST_K) ? AFTER_PAY : PB_PAY_RD;
                end
            end
`ifdef PKT_CHECKSUM_EN
            PB_CSUM: begin
                out_valid = 1'b1;
                out_byte  = csum_q;
                out_last  = 1'b1;
                if (out_ready) begin
                    state_nxt = PB_DONE;
                end
            end
`endif
            PB_DONE: begin
                busy       = 1'b0;
                packetsent = 1'b1;
                state_nxt  = PB_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = PB_IDLE;
            end
        endcase
    end

    // Field capture, byte/payload counters, RAM addressing and checksum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_q    <= '0;
            ack_q    <= '0;
            flags_q  <= '0;
            base_q   <= '0;
            hdr_cnt  <= '0;
            k_q      <= '0;
            pay_q    <= '0;
            pay_held <= 1'b0;
            mem_addr <= '0;
`ifdef PKT_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            case (state)
                PB_IDLE: begin
                    if (start) begin
                        seq_q    <= seq_in;
                        ack_q    <= ack_in;
                        flags_q  <= flags_in;
                        base_q   <= ADDR_W'(idx_w * 32'(PAYLOAD_BYTES));
                        hdr_cnt  <= '0;
                        k_q      <= '0;
                        pay_held <= 1'b0;
                    end
                end
                PB_HDR: begin
                    if (hs) begin
                        hdr_cnt <= hdr_cnt + 4'd1;
                        if ((hdr_cnt == LAST_HDR) && pay_en) begin
                            mem_addr <= base_q;
                            k_q      <= '0;
                        end
                    end
                end
                PB_PAY: begin
                    if (hs) begin
                        pay_held <= 1'b0;
                        if (k_q != LAST_K) begin
                            k_q      <= k_q + 8'd1;
                            mem_addr <= base_q + ADDR_W'(k_q) + ADDR_W'(1);
                        end
                    end else if (!pay_held) begin
                        pay_q    <= mem_rdata;
                        pay_held <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
`ifdef PKT_CHECKSUM_EN
            if ((state == PB_IDLE) && start) begin
                csum_q <= '0;
            end else if (hs) begin
                csum_q <= csum_q ^ out_byte;
            end
`endif
        end
    end

endmodule
